bios_mem_arbiter: RTL and testbench

- Shares the single-port, 4096-word BIOS memory between two requesters: port 0 (CPU data path) and port 1 (UART program loader / debug).
- Grants at most one access per cycle, using round-robin arbitration when both ports request.
- Returns read data to the issuing port with fixed 1-cycle latency.
- Keeps per-port stall counters for performance and debug visibility.

---
 rtl/bios_mem_arbiter.sv | 127 ++++++++++++
 tb/tb_bios_mem_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bios_mem_arbiter.sv
// Two-port round-robin arbiter in front of the single-port BIOS memory.
// Grants are combinational, read data returns one cycle later, and each port has a saturating stall counter.
module bios_mem_arbiter #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    p0_req_valid,
    output logic                    p0_req_ready,
    input  logic [ADDR_WIDTH-1:0]   p0_addr,
    input  logic [DATA_WIDTH-1:0]   p0_wdata,
    input  logic [DATA_WIDTH/8-1:0] p0_wbe,
    output logic                    p0_rsp_valid,
    output logic [DATA_WIDTH-1:0]   p0_rdata,

    input  logic                    p1_req_valid,
    output logic                    p1_req_ready,
    input  logic [ADDR_WIDTH-1:0]   p1_addr,
    input  logic [DATA_WIDTH-1:0]   p1_wdata,
    input  logic [DATA_WIDTH/8-1:0] p1_wbe,
    output logic                    p1_rsp_valid,
    output logic [DATA_WIDTH-1:0]   p1_rdata,

    output logic                    mem_en,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_din,
    output logic [DATA_WIDTH/8-1:0] mem_we,
    input  logic [DATA_WIDTH-1:0]   mem_dout,

    input  logic                    stall_clr,
    output logic [CNT_WIDTH-1:0]    p0_stall_cnt,
    output logic [CNT_WIDTH-1:0]    p1_stall_cnt
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    logic                 gnt0, gnt1;
    logic                 prio_q, prio_d;
    logic                 rsp_pending_q, rsp_pending_d;
    logic                 rsp_owner_q, rsp_owner_d;
    logic [CNT_WIDTH-1:0] p0_stall_q, p0_stall_d;
    logic [CNT_WIDTH-1:0] p1_stall_q, p1_stall_d;

    // prio names the port that wins when both request.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            if (p0_req_valid && p1_req_valid) begin
                gnt0 = ~prio_q;
                gnt1 = prio_q;
            end else begin
                gnt0 = p0_req_valid;
                gnt1 = p1_req_valid;
            end
        end
    end

    assign p0_req_ready = gnt0;
    assign p1_req_ready = gnt1;

    always_comb begin
        mem_en   = 1'b0;
        mem_addr = '0;
        mem_din  = '0;
        mem_we   = '0;
        if (gnt0) begin
            mem_en   = 1'b1;
            mem_addr = p0_addr;
            mem_din  = p0_wdata;
            mem_we   = p0_wbe;
        end else if (gnt1) begin
            mem_en   = 1'b1;
            mem_addr = p1_addr;
            mem_din  = p1_wdata;
            mem_we   = p1_wbe;
        end
    end

    always_comb begin
        prio_d = prio_q;
        if (gnt0) begin
            prio_d = 1'b1;
        end else if (gnt1) begin
            prio_d = 1'b0;
        end
        rsp_pending_d = mem_en && (mem_we == {BE_WIDTH{1'b0}});
        rsp_owner_d   = gnt1;
    end

    // Continuous assigns keep the next-state counters easy to probe and override from a bench.
    assign p0_stall_d = stall_clr ? '0 :
                        (p0_req_valid && !gnt0 && p0_stall_q != CNT_MAX) ? p0_stall_q + CNT_ONE :
                        p0_stall_q;
    assign p1_stall_d = stall_clr ? '0 :
                        (p1_req_valid && !gnt1 && p1_stall_q != CNT_MAX) ? p1_stall_q + CNT_ONE :
                        p1_stall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_q        <= 1'b0;
            rsp_pending_q <= 1'b0;
            rsp_owner_q   <= 1'b0;
            p0_stall_q    <= '0;
            p1_stall_q    <= '0;
        end else begin
            prio_q        <= prio_d;
            rsp_pending_q <= rsp_pending_d;
            rsp_owner_q   <= rsp_owner_d;
            p0_stall_q    <= p0_stall_d;
            p1_stall_q    <= p1_stall_d;
        end
    end

    assign p0_rsp_valid = rsp_pending_q && !rsp_owner_q;
    assign p1_rsp_valid = rsp_pending_q &&  rsp_owner_q;
    assign p0_rdata     = mem_dout;
    assign p1_rdata     = mem_dout;
    assign p0_stall_cnt = p0_stall_q;
    assign p1_stall_cnt = p1_stall_q;

endmodule

// File: tb/tb_bios_mem_arbiter.sv
// Bench for bios_mem_arbiter: vector table, hand sequences and random traffic
// against a transaction-level reference model with its own shadow memory.
module tb_bios_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        p0_req_valid = 1'b0, p1_req_valid = 1'b0;
    logic        p0_req_ready, p1_req_ready;
    logic [11:0] p0_addr = '0, p1_addr = '0;
    logic [31:0] p0_wdata = '0, p1_wdata = '0;
    logic [3:0]  p0_wbe = '0, p1_wbe = '0;
    logic        p0_rsp_valid, p1_rsp_valid;
    logic [31:0] p0_rdata, p1_rdata;
    logic        mem_en;
    logic [11:0] mem_addr;
    logic [31:0] mem_din;
    logic [3:0]  mem_we;
    logic [31:0] mem_dout;
    logic        stall_clr = 1'b0;
    logic [31:0] p0_stall_cnt, p1_stall_cnt;

    bios_mem_arbiter #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_wbe(p0_wbe), .p0_rsp_valid(p0_rsp_valid), .p0_rdata(p0_rdata),
        .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_wbe(p1_wbe), .p1_rsp_valid(p1_rsp_valid), .p1_rdata(p1_rdata),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout),
        .stall_clr(stall_clr), .p0_stall_cnt(p0_stall_cnt), .p1_stall_cnt(p1_stall_cnt)
    );

    always #5 clk = ~clk;

    // Synchronous single-port memory seen by the DUT
    logic [31:0] mem_arr [4096];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we != 4'b0000) begin
                for (int b = 0; b < 4; b++)
                    if (mem_we[b]) mem_arr[mem_addr][b*8 +: 8] <= mem_din[b*8 +: 8];
            end else begin
                mem_dout <= mem_arr[mem_addr];
            end
        end
    end

    // Reference model state
    logic [31:0] ref_mem [4096];
    int          m_prio;
    int          m_g;
    bit          m_rsp_v [2];
    logic [31:0] m_rsp_d;
    logic [31:0] m_stall [2];

    int n_err = 0;
    int n_chk = 0;

    function automatic logic [31:0] init_word(int i);
        if (i == 'h020) return 32'h11223344;
        return 32'hC0DE0000 | i;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_prio = 0;
        m_rsp_v[0] = 0;
        m_rsp_v[1] = 0;
        m_stall[0] = 0;
        m_stall[1] = 0;
    endtask

    task automatic drive(input bit r, input bit v0, input logic [11:0] a0, input logic [31:0] d0,
                         input logic [3:0] be0, input bit v1, input logic [11:0] a1,
                         input logic [31:0] d1, input logic [3:0] be1, input bit clr);
        rst = r;
        p0_req_valid = v0; p0_addr = a0; p0_wdata = d0; p0_wbe = be0;
        p1_req_valid = v1; p1_addr = a1; p1_wdata = d1; p1_wbe = be1;
        stall_clr = clr;
        if (r) model_clear();
    endtask

    task automatic model_check();
        logic [11:0] ea;
        logic [31:0] ed;
        logic [3:0]  ew;
        m_g = -1;
        if (!rst) begin
            if (p0_req_valid && p1_req_valid) m_g = m_prio;
            else if (p0_req_valid)            m_g = 0;
            else if (p1_req_valid)            m_g = 1;
        end
        ea = '0; ed = '0; ew = '0;
        if (m_g == 0) begin ea = p0_addr; ed = p0_wdata; ew = p0_wbe; end
        if (m_g == 1) begin ea = p1_addr; ed = p1_wdata; ew = p1_wbe; end
        chk("p0_req_ready", p0_req_ready, m_g == 0);
        chk("p1_req_ready", p1_req_ready, m_g == 1);
        chk("mem_en", mem_en, m_g >= 0);
        chk("mem_addr", mem_addr, ea);
        chk("mem_din", mem_din, ed);
        chk("mem_we", mem_we, ew);
        chk("p0_rsp_valid", p0_rsp_valid, m_rsp_v[0]);
        chk("p1_rsp_valid", p1_rsp_valid, m_rsp_v[1]);
        if (m_rsp_v[0]) chk("p0_rdata", p0_rdata, m_rsp_d);
        if (m_rsp_v[1]) chk("p1_rdata", p1_rdata, m_rsp_d);
        chk("p0_stall_cnt", p0_stall_cnt, m_stall[0]);
        chk("p1_stall_cnt", p1_stall_cnt, m_stall[1]);
    endtask

    // Advances the model by one accepted-transaction step at the clock edge
    task automatic model_update();
        bit          nv [2];
        logic [11:0] a;
        logic [31:0] d;
        logic [3:0]  be;
        bit          vld [2];
        if (rst) return;
        nv[0] = 0; nv[1] = 0;
        vld[0] = p0_req_valid; vld[1] = p1_req_valid;
        if (m_g >= 0) begin
            a  = (m_g == 0) ? p0_addr  : p1_addr;
            d  = (m_g == 0) ? p0_wdata : p1_wdata;
            be = (m_g == 0) ? p0_wbe   : p1_wbe;
            if (be != 4'b0000) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) ref_mem[a][b*8 +: 8] = d[b*8 +: 8];
            end else begin
                nv[m_g] = 1;
                m_rsp_d = ref_mem[a];
            end
            m_prio = 1 - m_g;
        end
        for (int k = 0; k < 2; k++) begin
            if (stall_clr) m_stall[k] = 0;
            else if (vld[k] && m_g != k && m_stall[k] != 32'hFFFFFFFF) m_stall[k] = m_stall[k] + 1;
        end
        m_rsp_v[0] = nv[0];
        m_rsp_v[1] = nv[1];
    endtask

    task automatic finish_cycle();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic cycle();
        #2;
        model_check();
        finish_cycle();
    endtask

    typedef struct {
        bit          rst;
        bit          v0;
        logic [11:0] a0;
        logic [31:0] d0;
        logic [3:0]  be0;
        bit          v1;
        logic [11:0] a1;
        bit          e_rdy0, e_rdy1, e_rsp0, e_rsp1;
        logic [31:0] e_rdata;
        logic [31:0] e_cnt0, e_cnt1;
    } vec_t;

    vec_t tbl [$];

    function automatic vec_t V(bit r, bit v0, logic [11:0] a0, logic [31:0] d0, logic [3:0] be0,
                               bit v1, logic [11:0] a1, bit r0, bit r1, bit s0, bit s1,
                               logic [31:0] rd, logic [31:0] c0, logic [31:0] c1);
        vec_t v;
        v.rst = r; v.v0 = v0; v.a0 = a0; v.d0 = d0; v.be0 = be0; v.v1 = v1; v.a1 = a1;
        v.e_rdy0 = r0; v.e_rdy1 = r1; v.e_rsp0 = s0; v.e_rsp1 = s1;
        v.e_rdata = rd; v.e_cnt0 = c0; v.e_cnt1 = c1;
        return v;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, limit 100000 reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rsp_seen;
        for (int i = 0; i < 4096; i++) begin
            mem_arr[i] = init_word(i);
            ref_mem[i] = init_word(i);
        end
        model_clear();

        // write then read back
        tbl.push_back(V(1, 0, 0, 0, 0, 0, 0,           0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(V(0, 1, 'h010, 'hDEADBEEF, 'hF, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(V(0, 1, 'h010, 0, 0, 0, 0,       1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(V(0, 0, 0, 0, 0, 0, 0,           0, 0, 1, 0, 'hDEADBEEF, 0, 0));
        // continuous contention from reset
        tbl.push_back(V(1, 0, 0, 0, 0, 0, 0,           0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(V(0, 1, 1, 0, 0, 1, 2,           1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(V(0, 1, 1, 0, 0, 1, 2,           0, 1, 1, 0, 'hC0DE0001, 0, 1));
        tbl.push_back(V(0, 1, 1, 0, 0, 1, 2,           1, 0, 0, 1, 'hC0DE0002, 1, 1));
        tbl.push_back(V(0, 1, 1, 0, 0, 1, 2,           0, 1, 1, 0, 'hC0DE0001, 1, 2));
        tbl.push_back(V(0, 1, 1, 0, 0, 1, 2,           1, 0, 0, 1, 'hC0DE0002, 2, 2));
        tbl.push_back(V(0, 1, 1, 0, 0, 1, 2,           0, 1, 1, 0, 'hC0DE0001, 2, 3));
        tbl.push_back(V(0, 0, 0, 0, 0, 0, 0,           0, 0, 0, 1, 'hC0DE0002, 3, 3));
        // partial byte write
        tbl.push_back(V(1, 0, 0, 0, 0, 0, 0,           0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(V(0, 1, 'h020, 'hAA, 'h1, 0, 0,  1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(V(0, 1, 'h020, 0, 0, 0, 0,       1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(V(0, 0, 0, 0, 0, 0, 0,           0, 0, 1, 0, 'h112233AA, 0, 0));
        // reset with a read outstanding
        tbl.push_back(V(1, 0, 0, 0, 0, 0, 0,           0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(V(0, 1, 3, 0, 0, 1, 2,           1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(V(0, 1, 5, 0, 0, 0, 0,           1, 0, 1, 0, 'hC0DE0003, 0, 1));
        tbl.push_back(V(1, 0, 0, 0, 0, 0, 0,           0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(V(0, 1, 7, 0, 0, 1, 2,           1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(V(0, 0, 0, 0, 0, 0, 0,           0, 0, 1, 0, 'hC0DE0007, 0, 1));

        @(negedge clk);
        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].v0, tbl[i].a0, tbl[i].d0, tbl[i].be0,
                  tbl[i].v1, tbl[i].a1, 32'h0, 4'h0, 1'b0);
            #2;
            model_check();
            chk($sformatf("tbl%0d_rdy0", i), p0_req_ready, tbl[i].e_rdy0);
            chk($sformatf("tbl%0d_rdy1", i), p1_req_ready, tbl[i].e_rdy1);
            chk($sformatf("tbl%0d_rsp0", i), p0_rsp_valid, tbl[i].e_rsp0);
            chk($sformatf("tbl%0d_rsp1", i), p1_rsp_valid, tbl[i].e_rsp1);
            if (tbl[i].e_rsp0) chk($sformatf("tbl%0d_rdata0", i), p0_rdata, tbl[i].e_rdata);
            if (tbl[i].e_rsp1) chk($sformatf("tbl%0d_rdata1", i), p1_rdata, tbl[i].e_rdata);
            chk($sformatf("tbl%0d_cnt0", i), p0_stall_cnt, tbl[i].e_cnt0);
            chk($sformatf("tbl%0d_cnt1", i), p1_stall_cnt, tbl[i].e_cnt1);
            finish_cycle();
        end

        // port 1 streaming reads at full throughput
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        rsp_seen = 0;
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 0, 0, 0, i < 8, 12'(i), 0, 0, 0);
            #2;
            model_check();
            if (i < 8) chk("stream_rdy1", p1_req_ready, 1'b1);
            if (i >= 1 && i <= 8) begin
                chk("stream_rsp1", p1_rsp_valid, 1'b1);
                chk("stream_rdata1", p1_rdata, 32'hC0DE0000 | (i - 1));
            end
            if (p1_rsp_valid) rsp_seen++;
            finish_cycle();
        end
        chk("stream_rsp_count", rsp_seen, 8);
        chk("stream_stall1", p1_stall_cnt, 0);

        // counter saturation and clear
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        model_check();
        force dut.p1_stall_d = 32'hFFFFFFFE;
        @(posedge clk);
        model_update();
        m_stall[1] = 32'hFFFFFFFE;
        #1;
        release dut.p1_stall_d;
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            drive(0, 1, 12'h001, 0, 0, 1, 12'h002, 0, 0, 0);
            cycle();
        end
        drive(0, 1, 12'h001, 0, 0, 1, 12'h002, 0, 0, 1);
        #2;
        model_check();
        chk("sat_hold", p1_stall_cnt, 32'hFFFFFFFF);
        chk("clr_rdy1_stalled", p1_req_ready, 1'b0);
        finish_cycle();
        drive(0, 1, 12'h001, 0, 0, 1, 12'h002, 0, 0, 0);
        #2;
        model_check();
        chk("clr_zero", p1_stall_cnt, 0);
        finish_cycle();
        #2;
        model_check();
        chk("clr_still_zero", p1_stall_cnt, 0);
        finish_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        model_check();
        chk("clr_then_inc", p1_stall_cnt, 1);
        finish_cycle();

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            bit          r, v0, v1, clr;
            logic [3:0]  be0, be1;
            r   = ($urandom_range(0, 99) < 2);
            clr = ($urandom_range(0, 99) < 5);
            v0  = ($urandom_range(0, 99) < 60);
            v1  = ($urandom_range(0, 99) < 60);
            be0 = $urandom_range(0, 1) ? 4'($urandom) : 4'h0;
            be1 = $urandom_range(0, 1) ? 4'($urandom) : 4'h0;
            drive(r, v0, 12'($urandom_range(0, 15)), $urandom, be0,
                  v1, 12'($urandom_range(0, 15)), $urandom, be1, clr);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
